// File: rtl/pmem_line_responder.sv
// Fixed-latency 128-bit line memory behind the L1 pmem port.
// Define PMEM_STATS_EN to add completed read/write counters.
module pmem_line_responder #(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp
`ifdef PMEM_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int IW = $clog2(DEPTH_LINES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    TURN
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_cnt, w_cnt;
  logic            r_op, w_op;
  logic [IW-1:0]   r_idx, w_idx;
  logic [127:0]    r_wdata, w_wdata;
  logic [127:0]    r_rdata;
  logic [127:0]    r_mem [DEPTH_LINES];

  logic [IW-1:0]   w_addr_idx;
  logic            w_req_held;
  logic            w_rd_load;
  logic            w_unused;

  // Bits [3:0] and bits above the index are don't-care.
  assign w_addr_idx = pmem_address[4+IW-1:4];
  assign w_unused   = ^pmem_address;
  assign w_req_held = r_op ? pmem_write : pmem_read;

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_op    = r_op;
    w_idx   = r_idx;
    w_wdata = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (pmem_write || pmem_read) begin
          w_op   = pmem_write;
          w_idx  = w_addr_idx;
          if (pmem_write)
            w_wdata = pmem_wdata;
          w_cnt  = 8'(LATENCY - 1);
          w_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!w_req_held) begin
          w_next = IDLE;
        end else begin
          w_cnt = r_cnt - 8'd1;
          if (r_cnt <= 8'd1)
            w_next = RESP;
        end
      end
      RESP:    w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Read data is registered on the edge entering RESP.
  assign w_rd_load = (w_next == RESP) && !w_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_op    <= w_op;
      r_idx   <= w_idx;
      r_wdata <= w_wdata;
      if (w_rd_load)
        r_rdata <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == RESP && r_op)
      r_mem[r_idx] <= r_wdata;
  end

  assign pmem_rdata = r_rdata;
  assign pmem_resp  = (r_state == RESP);

`ifdef PMEM_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (r_state == RESP) begin
      if (r_op && r_wr_count != 16'hFFFF)
        r_wr_count <= r_wr_count + 16'd1;
      if (!r_op && r_rd_count != 16'hFFFF)
        r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule
